// File: rtl/shift_seq.sv
`default_nettype none
// ============================================================================
// Module   : shift_seq
// Purpose  : Iterative ARM operand-2 shifter (LSL/LSR/ASR/ROR/RRX), STEP bits
//            per cycle, with start/busy/done handshake and shifter carry-out.
// Revision : 1.0 - initial release
// ============================================================================
module shift_seq #(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  sh,
    input  logic        imm,
    input  logic [4:0]  shamt5,
    input  logic [31:0] rs,
    input  logic [31:0] rm,
    input  logic        cin,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        cout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_LSL = 3'd0,
        OP_LSR = 3'd1,
        OP_ASR = 3'd2,
        OP_ROR = 3'd3,
        OP_RRX = 3'd4
    } op_t;

    localparam logic [5:0] c_step = 6'(STEP);

    state_t      r_state;
    op_t         r_op;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_result;
    logic        r_cout;
    logic [5:0]  r_remaining;

    op_t         w_op;
    logic [5:0]  w_n;
    logic        w_cin0;
    logic [5:0]  w_k;
    logic [31:0] w_step_v;
    logic        w_step_c;
    logic        w_unused_rs;

    assign w_unused_rs = ^rs[31:8];

    // Amount decode: number of 1-bit steps plus the op and carry to preload.
    always_comb begin
        w_n    = 6'd0;
        w_op   = op_t'({1'b0, sh});
        w_cin0 = cin;
        if (imm) begin
            if (shamt5 != 5'd0) begin
                w_n = {1'b0, shamt5};
            end else begin
                case (sh)
                    2'b01, 2'b10: w_n = 6'd32;
                    2'b11: begin
                        w_op = OP_RRX;
                        w_n  = 6'd1;
                    end
                    default: w_n = 6'd0;
                endcase
            end
        end else if (rs[7:0] != 8'd0) begin
            case (sh)
                2'b00, 2'b01: w_n = (rs[7:0] > 8'd33) ? 6'd33 : rs[5:0];
                2'b10:        w_n = (rs[7:0] > 8'd32) ? 6'd32 : rs[5:0];
                default: begin
                    if (rs[4:0] == 5'd0) begin
                        w_cin0 = rm[31];
                    end else begin
                        w_n = {1'b0, rs[4:0]};
                    end
                end
            endcase
        end
    end

    assign w_k = (r_remaining < c_step) ? r_remaining : c_step;

    // A k-bit step is built from k chained 1-bit steps; the carry of the last
    // one equals the ARM carry of the k-bit shift for every op.
    always_comb begin
        w_step_v = r_result;
        w_step_c = r_cout;
        for (int i = 0; i < STEP; i++) begin
            if (6'(i) < r_remaining) begin
                case (r_op)
                    OP_LSL: begin
                        w_step_c = w_step_v[31];
                        w_step_v = {w_step_v[30:0], 1'b0};
                    end
                    OP_LSR: begin
                        w_step_c = w_step_v[0];
                        w_step_v = {1'b0, w_step_v[31:1]};
                    end
                    OP_ASR: begin
                        w_step_c = w_step_v[0];
                        w_step_v = {w_step_v[31], w_step_v[31:1]};
                    end
                    OP_ROR: begin
                        w_step_c = w_step_v[0];
                        w_step_v = {w_step_v[0], w_step_v[31:1]};
                    end
                    default: begin
                        {w_step_c, w_step_v} = {w_step_v[0], w_step_c, w_step_v[31:1]};
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_op        <= OP_LSL;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_result    <= 32'd0;
            r_cout      <= 1'b0;
            r_remaining <= 6'd0;
        end else begin
            case (r_state)
                S_SHIFT: begin
                    r_result    <= w_step_v;
                    r_cout      <= w_step_c;
                    r_remaining <= r_remaining - w_k;
                    if (r_remaining == w_k) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    if (start) begin
                        r_result    <= rm;
                        r_cout      <= w_cin0;
                        r_op        <= w_op;
                        r_remaining <= w_n;
                        if (w_n == 6'd0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_SHIFT;
                            r_busy  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign cout   = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_shift_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_seq
// Purpose  : Bench for shift_seq; STEP=1 and STEP=4 instances share stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  sh = 2'd0;
    logic        imm = 1'b0;
    logic [4:0]  shamt5 = 5'd0;
    logic [31:0] rs = 32'd0;
    logic [31:0] rm = 32'd0;
    logic        cin = 1'b0;

    logic [1:0]  d_busy;
    logic [1:0]  d_done;
    logic [31:0] d_res [2];
    logic [1:0]  d_cout;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    shift_seq #(.STEP(1)) u_s1 (
        .clk(clk), .reset(reset), .start(start), .sh(sh), .imm(imm),
        .shamt5(shamt5), .rs(rs), .rm(rm), .cin(cin),
        .busy(d_busy[0]), .done(d_done[0]), .result(d_res[0]), .cout(d_cout[0])
    );

    shift_seq #(.STEP(4)) u_s4 (
        .clk(clk), .reset(reset), .start(start), .sh(sh), .imm(imm),
        .shamt5(shamt5), .rs(rs), .rm(rm), .cin(cin),
        .busy(d_busy[1]), .done(d_done[1]), .result(d_res[1]), .cout(d_cout[1])
    );

    function automatic int step_of(input int j);
        return (j == 0) ? 1 : 4;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Final ARM shifter result straight from the architectural rules.
    function automatic void ref_shift(input logic [1:0] s, input logic i, input logic [4:0] sa,
                                      input logic [31:0] r_s, input logic [31:0] m, input logic c,
                                      output logic [31:0] res, output logic co, output int n);
        int a;
        res = m;
        co  = c;
        n   = 0;
        if (i) begin
            a = int'(sa);
            if (a == 0) begin
                if (s == 2'd1) begin res = 32'd0; co = m[31]; n = 32; end
                else if (s == 2'd2) begin res = {32{m[31]}}; co = m[31]; n = 32; end
                else if (s == 2'd3) begin res = {c, m[31:1]}; co = m[0]; n = 1; end
            end else begin
                n = a;
                case (s)
                    2'd0: begin res = m << a; co = m[32-a]; end
                    2'd1: begin res = m >> a; co = m[a-1]; end
                    2'd2: begin res = 32'($signed(m) >>> a); co = m[a-1]; end
                    default: begin res = (m >> a) | (m << (32 - a)); co = res[31]; end
                endcase
            end
        end else begin
            a = int'(r_s[7:0]);
            if (a != 0) begin
                case (s)
                    2'd0: begin
                        n = (a > 33) ? 33 : a;
                        if (a > 32) begin res = 32'd0; co = 1'b0; end
                        else if (a == 32) begin res = 32'd0; co = m[0]; end
                        else begin res = m << a; co = m[32-a]; end
                    end
                    2'd1: begin
                        n = (a > 33) ? 33 : a;
                        if (a > 32) begin res = 32'd0; co = 1'b0; end
                        else if (a == 32) begin res = 32'd0; co = m[31]; end
                        else begin res = m >> a; co = m[a-1]; end
                    end
                    2'd2: begin
                        n = (a > 32) ? 32 : a;
                        if (a >= 32) begin res = {32{m[31]}}; co = m[31]; end
                        else begin res = 32'($signed(m) >>> a); co = m[a-1]; end
                    end
                    default: begin
                        a = a % 32;
                        if (a == 0) co = m[31];
                        else begin n = a; res = (m >> a) | (m << (32 - a)); co = res[31]; end
                    end
                endcase
            end
        end
    endfunction

    logic        m_busy [2];
    logic        m_done [2];
    logic [31:0] m_res  [2];
    logic        m_cout [2];
    int          m_left [2];
    logic [31:0] p_res  [2];
    logic        p_c    [2];

    // Model: accept when not mid-shift, done ceil(n/STEP) edges later.
    always @(posedge clk or negedge reset) begin
        logic [31:0] fr;
        logic        fc;
        int          fn;
        int          lat;
        if (!reset) begin
            for (int j = 0; j < 2; j++) begin
                m_busy[j] <= 1'b0; m_done[j] <= 1'b0; m_res[j] <= 32'd0;
                m_cout[j] <= 1'b0; m_left[j] <= 0;
            end
        end else begin
            ref_shift(sh, imm, shamt5, rs, rm, cin, fr, fc, fn);
            for (int j = 0; j < 2; j++) begin
                lat = (fn + step_of(j) - 1) / step_of(j);
                if (m_left[j] > 0) begin
                    m_left[j] <= m_left[j] - 1;
                    if (m_left[j] == 1) begin
                        m_busy[j] <= 1'b0; m_done[j] <= 1'b1;
                        m_res[j]  <= p_res[j]; m_cout[j] <= p_c[j];
                    end
                end else if (start) begin
                    m_left[j] <= lat; p_res[j] <= fr; p_c[j] <= fc;
                    if (lat == 0) begin
                        m_busy[j] <= 1'b0; m_done[j] <= 1'b1;
                        m_res[j]  <= fr; m_cout[j] <= fc;
                    end else begin
                        m_busy[j] <= 1'b1; m_done[j] <= 1'b0;
                    end
                end else begin
                    m_done[j] <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int j = 0; j < 2; j++) begin
            chk($sformatf("s%0d busy", step_of(j)), d_busy[j], m_busy[j]);
            chk($sformatf("s%0d done", step_of(j)), d_done[j], m_done[j]);
            if (!m_busy[j]) begin
                chk($sformatf("s%0d result", step_of(j)), d_res[j], m_res[j]);
                chk($sformatf("s%0d cout", step_of(j)), d_cout[j], m_cout[j]);
            end
        end
    end

    task automatic drive(input logic [1:0] s, input logic i, input logic [4:0] sa,
                         input logic [31:0] r_s, input logic [31:0] m, input logic c);
        sh = s; imm = i; shamt5 = sa; rs = r_s; rm = m; cin = c; start = 1'b1;
    endtask

    task automatic wait_done(input string nm, input int xl1, input int xl4,
                             input logic [31:0] xr, input logic xc);
        int l1 = -1;
        int l4 = -1;
        for (int e = 1; e <= 40; e++) begin
            if (l1 >= 0 && l4 >= 0) break;
            @(posedge clk); #1;
            start = 1'b0;
            if (l1 < 0 && d_done[0]) l1 = e;
            if (l4 < 0 && d_done[1]) l4 = e;
        end
        chk({nm, " lat s1"}, l1, xl1);
        chk({nm, " lat s4"}, l4, xl4);
        chk({nm, " res s1"}, d_res[0], xr);
        chk({nm, " cout s1"}, d_cout[0], xc);
        chk({nm, " res s4"}, d_res[1], xr);
        chk({nm, " cout s4"}, d_cout[1], xc);
    endtask

    task automatic do_op(input string nm, input logic [1:0] s, input logic i, input logic [4:0] sa,
                         input logic [31:0] r_s, input logic [31:0] m, input logic c,
                         input logic [31:0] xr, input logic xc, input int xl1, input int xl4);
        @(negedge clk);
        drive(s, i, sa, r_s, m, c);
        wait_done(nm, xl1, xl4, xr, xc);
    endtask

    initial begin
        #100000;
        n_bad++;
        $display("FAIL timeout: bench did not finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            chk("reset busy", d_busy[j], 1'b0);
            chk("reset done", d_done[j], 1'b0);
            chk("reset result", d_res[j], 32'd0);
            chk("reset cout", d_cout[j], 1'b0);
        end
        #2 reset = 1'b1;

        //     name        sh    imm shamt  rs            rm            cin  result        cout s1 s4
        do_op("lsl_imm1",  2'd0, 1, 5'd1,  32'h0,        32'h80000001, 0, 32'h00000002, 1,  2, 2);
        do_op("lsr_rs33",  2'd1, 0, 5'd0,  32'h00000021, 32'hFFFFFFFF, 0, 32'h00000000, 0, 34, 10);
        do_op("asr_imm0",  2'd2, 1, 5'd0,  32'h0,        32'h80000000, 0, 32'hFFFFFFFF, 1, 33, 9);
        do_op("rrx",       2'd3, 1, 5'd0,  32'h0,        32'h00000003, 1, 32'h80000001, 1,  2, 2);
        do_op("ror_rs32",  2'd3, 0, 5'd0,  32'h00000020, 32'h80000000, 0, 32'h80000000, 1,  1, 1);
        do_op("lsl_rs32",  2'd0, 0, 5'd0,  32'h00000020, 32'h00000001, 0, 32'h00000000, 1, 33, 9);
        do_op("ror_imm4",  2'd3, 1, 5'd4,  32'h0,        32'h0000000F, 0, 32'hF0000000, 1,  5, 2);
        do_op("lsl_rs0",   2'd0, 0, 5'd0,  32'hFFFFFF00, 32'h12345678, 1, 32'h12345678, 1,  1, 1);
        do_op("asr_rsff",  2'd2, 0, 5'd0,  32'h000000FF, 32'h7FFFFFFF, 1, 32'h00000000, 0, 33, 9);
        do_op("lsr_imm0",  2'd1, 1, 5'd0,  32'h0,        32'h80000000, 0, 32'h00000000, 1, 33, 9);
        do_op("lsl_imm0",  2'd0, 1, 5'd0,  32'h0,        32'h0000000A, 0, 32'h0000000A, 0,  1, 1);
        do_op("asr_imm5",  2'd2, 1, 5'd5,  32'h0,        32'h80000010, 0, 32'hFC000000, 1,  6, 3);
        do_op("ror_rs25",  2'd3, 0, 5'd0,  32'h00000025, 32'h00000021, 1, 32'h08000001, 0,  6, 3);
        do_op("lsr_rshi",  2'd1, 0, 5'd0,  32'hFFFFFF03, 32'h000000F0, 1, 32'h0000001E, 0,  4, 2);

        // Start during SHIFT is ignored.
        @(negedge clk);
        drive(2'd0, 0, 5'd0, 32'h00000008, 32'h000000FF, 0);
        @(posedge clk); #1;
        drive(2'd1, 0, 5'd0, 32'h00000001, 32'h12345678, 1);
        @(posedge clk); #1;
        start = 1'b0;
        chk("ign busy s1", d_busy[0], 1'b1);
        chk("ign busy s4", d_busy[1], 1'b1);
        wait_done("ignore", 7, 1, 32'h0000FF00, 0);

        // Back-to-back start accepted in DONE.
        @(negedge clk);
        drive(2'd0, 1, 5'd1, 32'h0, 32'h80000001, 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("b2b done s1", d_done[0], 1'b1);
        chk("b2b done s4", d_done[1], 1'b1);
        drive(2'd1, 1, 5'd4, 32'h0, 32'h000000F0, 0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b busy s1", d_busy[0], 1'b1);
        chk("b2b busy s4", d_busy[1], 1'b1);
        wait_done("b2b", 4, 1, 32'h0000000F, 0);

        // Asynchronous reset mid-shift.
        @(negedge clk);
        drive(2'd0, 0, 5'd0, 32'd20, 32'hFFFFFFFF, 0);
        repeat (3) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("pre-rst busy s1", d_busy[0], 1'b1);
        chk("pre-rst busy s4", d_busy[1], 1'b1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        for (int j = 0; j < 2; j++) begin
            chk("arst busy", d_busy[j], 1'b0);
            chk("arst done", d_done[j], 1'b0);
            chk("arst result", d_res[j], 32'd0);
            chk("arst cout", d_cout[j], 1'b0);
        end
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        do_op("post_rst",  2'd0, 1, 5'd4,  32'h0,        32'h0000000F, 0, 32'h000000F0, 0,  5, 2);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_seq.md
Name: shift_seq

Overview:
Multi-cycle sequencer that executes ARM data-processing operand-2 shifts (LSL/LSR/ASR/ROR/RRX) iteratively on the shift datapath. It shifts up to STEP bits per cycle and produces the ARM-correct result and shifter carry-out. It sits between the decoder and the ALU in the multi-cycle core and replaces the combinational shifter for register-specified amounts. A start/busy/done handshake lets the control FSM stall while the shift runs.

Parameters:
STEP, 1, bits shifted per cycle; legal values 1, 2, 4.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low; 0 clears all state
start  input  1  request; sampled only in IDLE or DONE
sh  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
imm  input  1  1 = amount from shamt5; 0 = amount from rs[7:0]
shamt5  input  5  immediate shift amount
rs  input  32  register shift amount; only bits [7:0] used
rm  input  32  value to shift
cin  input  1  current C flag
busy  output  1  high while in SHIFT
done  output  1  one-cycle pulse; result/cout valid
result  output  32  shifted value; held until next accepted start
cout  output  1  shifter carry-out; held with result

Behaviour:
- Reset (async, reset=0): state=IDLE; busy=0, done=0, result=0, cout=0, counter=0. Takes effect mid-operation; the in-flight shift is discarded and no done pulse is produced.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE --start--> SHIFT, or DONE if the step count n=0.
  - SHIFT: each edge applies k=min(STEP, remaining) bits and decrements remaining by k. The edge that takes remaining to 0 moves to DONE.
  - DONE: done=1 for exactly one cycle. Next edge goes to IDLE, or accepts a new start (back-to-back is legal).
- Accepted start latches rm, sh and cin, computes n, and preloads result=rm, cout=cin.
- start while in SHIFT is ignored; it is not queued.
- Amount decode (n = number of 1-bit steps):
  - imm=1, shamt5!=0: n=shamt5.
  - imm=1, shamt5=0: LSL n=0; LSR n=32; ASR n=32; ROR = RRX, one step, result={cin,rm[31:1]}, cout=rm[0].
  - imm=0, rs[7:0]=0: n=0 for all sh; result=rm, cout=cin.
  - imm=0, LSL/LSR: n=min(rs[7:0],33). Amount 32 gives result 0, cout=rm[0] (LSL) or rm[31] (LSR). Amounts ≥33 give result 0, cout 0.
  - imm=0, ASR: n=min(rs[7:0],32). Amounts ≥32 fill with the sign bit; cout=rm[31].
  - imm=0, ROR: if rs[4:0]=0, n=0, result=rm, cout=rm[31]; else n=rs[4:0].
- Per step of k bits:
  - LSL: cout=v[32-k], v<<k.
  - LSR: cout=v[k-1], logical right shift.
  - ASR: cout=v[k-1], arithmetic right shift.
  - ROR: rotate right, then cout=new v[31].
- Latency: done high 1+ceil(n/STEP) edges after the accepting edge's cycle. Minimum is 1 (n=0). Maximum with STEP=1 is 34.
- busy=1 exactly while state=SHIFT; busy and done are never both 1.
- result and cout are updated only by start and shift steps; they hold otherwise.

Test Plan:
- STEP=1, LSL imm shamt5=1, rm=0x80000001 -> done after 2 edges, result=0x00000002, cout=1.
- STEP=1, LSR reg rs=0x00000021, rm=0xFFFFFFFF -> busy for 33 cycles, done at edge 34, result=0x00000000, cout=0.
- ASR imm shamt5=0, rm=0x80000000 -> result=0xFFFFFFFF, cout=1. With STEP=4, done at edge 9.
- RRX (ROR imm 0): rm=0x00000003, cin=1 -> result=0x80000001, cout=1. ROR reg rs=0x20, rm=0x80000000 -> done at edge 1, result=0x80000000, cout=1.
- Assert start again during SHIFT with different operands -> ignored; first result completes unchanged. Assert start during DONE -> accepted, no idle gap.
- Drive reset=0 mid-SHIFT (LSL rs=20) -> busy, done, result and cout are 0 immediately (async). After release, IDLE and a new start works.
